// File: rtl/msx_pkg.sv
// Shared types and constants for the MSX slot decoder and RAM mapper.
//   page_t    : 16 KB page index, addr[15:14]
//   slot_t    : primary slot index
//   subslot_t : secondary (sub-)slot index
package msx_pkg;

  typedef logic [1:0] page_t;
  typedef logic [1:0] slot_t;
  typedef logic [1:0] subslot_t;

  // First of the four mapper segment ports FCh..FFh.
  localparam logic [7:0]  MapperPortBase = 8'hFC;
  // Memory address of the sub-slot register in an expanded slot.
  localparam logic [15:0] SubslotRegAddr = 16'hFFFF;

endpackage

// File: rtl/msx_subslot_reg.sv
// Sub-slot register of one expanded primary slot.
//   clk, reset : clock, asynchronous active-high reset (register clears to 00h)
//   we, wdata  : single-cycle write strobe and data
//   page       : page of the current access
//   rdata      : inverted register contents, as the CPU reads them back
//   sub        : sub-slot selected for the given page
module msx_subslot_reg
  import msx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] wdata,
  input  page_t      page,
  output logic [7:0] rdata,
  output subslot_t   sub
);

  logic [7:0] value_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= 8'h00;
    end else if (we) begin
      value_q <= wdata;
    end
  end

  assign rdata = ~value_q;

  // Two bits per page, page 0 in the low bits.
  always_comb begin
    sub = value_q[1:0];
    unique case (page)
      2'd0: sub = value_q[1:0];
      2'd1: sub = value_q[3:2];
      2'd2: sub = value_q[5:4];
      2'd3: sub = value_q[7:6];
      default: sub = value_q[1:0];
    endcase
  end

endmodule

// File: rtl/msx_slot_mapper.sv
// Primary/secondary slot decoder with an integrated MSX2-style RAM memory mapper.
// Optional feature macro: MAPPER_READBACK_EN (mapper ports FCh..FFh become readable).
//   clk, reset        : clock, asynchronous active-high reset
//   addr, d_from_cpu  : CPU address and write data
//   mreq_n .. rfrsh_n : Z80 bus strobes
//   ppi_a             : primary slot register, 2 bits per page
//   sltsl_n, subsl_n  : active-low primary and sub-slot selects (subsl index = slot*4+sub)
//   ram_addr, ram_we, ram_cs : mapped RAM interface
//   d_out, d_oe       : readback data for the CPU data multiplexer
module msx_slot_mapper
  import msx_pkg::*;
#(
  parameter logic [3:0]  EXPANDED    = 4'b1000,
  parameter int unsigned SEG_BITS    = 3,
  parameter int unsigned RAM_SLOT    = 3,
  parameter int unsigned RAM_SUBSLOT = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           addr,
  input  logic [7:0]            d_from_cpu,
  input  logic                  mreq_n,
  input  logic                  iorq_n,
  input  logic                  rd_n,
  input  logic                  wr_n,
  input  logic                  m1_n,
  input  logic                  rfrsh_n,
  input  logic [7:0]            ppi_a,
  output logic [3:0]            sltsl_n,
  output logic [15:0]           subsl_n,
  output logic [SEG_BITS+13:0]  ram_addr,
  output logic                  ram_we,
  output logic                  ram_cs,
  output logic [7:0]            d_out,
  output logic                  d_oe
);

  localparam slot_t    RamSlot     = slot_t'(RAM_SLOT);
  localparam subslot_t RamSub      = subslot_t'(RAM_SUBSLOT);
  localparam bit       RamExpanded = EXPANDED[RamSlot];

  page_t    page;
  slot_t    slot;
  subslot_t cur_sub;
  logic     mem_cycle;
  logic     io_cycle;
  logic     reg_addr;
  logic     slot_exp;
  logic     reg_hit;
  logic     reg_wr;
  logic     io_sel;
  logic     io_wr;
  logic     wr_q;
  logic     wr_fall;
  logic     ram_sub_ok;

  subslot_t sub_sel [4];
  logic [7:0] sub_rd [4];
  logic [SEG_BITS-1:0] seg_q [4];

  assign page = addr[15:14];

  always_comb begin
    slot = ppi_a[1:0];
    unique case (page)
      2'd0: slot = ppi_a[1:0];
      2'd1: slot = ppi_a[3:2];
      2'd2: slot = ppi_a[5:4];
      2'd3: slot = ppi_a[7:6];
      default: slot = ppi_a[1:0];
    endcase
  end

  assign mem_cycle = ~mreq_n & rfrsh_n;
  assign io_cycle  = ~iorq_n & m1_n;
  assign reg_addr  = (addr == SubslotRegAddr);
  assign slot_exp  = EXPANDED[slot];
  // FFFFh is in page 3, so slot is already the page-3 slot here.
  assign reg_hit   = mem_cycle & reg_addr & slot_exp;
  assign io_sel    = (addr[7:2] == MapperPortBase[7:2]);

  // Falling-edge detect on wr_n: one register update per bus write regardless of
  // wait states. Resetting wr_q low drops a write that straddles reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= 1'b0;
    end else begin
      wr_q <= wr_n;
    end
  end

  assign wr_fall = wr_q & ~wr_n;
  assign reg_wr  = reg_hit & wr_fall;
  assign io_wr   = io_cycle & io_sel & wr_fall;

  for (genvar i = 0; i < 4; i++) begin : g_slot
    if (EXPANDED[i]) begin : g_exp
      msx_subslot_reg u_subslot_reg (
        .clk   (clk),
        .reset (reset),
        .we    (reg_wr & (slot == slot_t'(i))),
        .wdata (d_from_cpu),
        .page  (page),
        .rdata (sub_rd[i]),
        .sub   (sub_sel[i])
      );
    end else begin : g_plain
      assign sub_rd[i]  = 8'hFF;
      assign sub_sel[i] = '0;
    end
  end

  assign cur_sub = sub_sel[slot];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        seg_q[k] <= SEG_BITS'(3 - k);
      end
    end else if (io_wr) begin
      seg_q[addr[1:0]] <= d_from_cpu[SEG_BITS-1:0];
    end
  end

  always_comb begin
    sltsl_n = 4'hF;
    subsl_n = 16'hFFFF;
    if (mem_cycle) begin
      sltsl_n[slot] = 1'b0;
      if (slot_exp && !reg_addr) begin
        subsl_n[{slot, cur_sub}] = 1'b0;
      end
    end
  end

  assign ram_sub_ok = !RamExpanded || (cur_sub == RamSub);
  assign ram_cs     = mem_cycle & ~reg_hit & (slot == RamSlot) & ram_sub_ok;
  assign ram_we     = ram_cs & ~wr_n;
  assign ram_addr   = {seg_q[page], addr[13:0]};

  always_comb begin
    d_out = 8'hFF;
    d_oe  = 1'b0;
    if (reg_hit && !rd_n) begin
      d_out = sub_rd[slot];
      d_oe  = 1'b1;
    end
`ifdef MAPPER_READBACK_EN
    else if (io_cycle && io_sel && !rd_n) begin
      // Unused upper bits read as ones.
      d_out                = 8'hFF;
      d_out[SEG_BITS-1:0]  = seg_q[addr[1:0]];
      d_oe                 = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_msx_slot_mapper.sv
module tb_msx_slot_mapper;

  localparam int SegBits = 3;

  logic clk = 1'b0;
  logic reset;
  logic [15:0] addr;
  logic [7:0]  d_from_cpu;
  logic mreq_n, iorq_n, rd_n, wr_n, m1_n, rfrsh_n;
  logic [7:0]  ppi_a;

  logic [3:0]  sltsl_n, sltsl_n_b;
  logic [15:0] subsl_n, subsl_n_b;
  logic [SegBits+13:0] ram_addr, ram_addr_b;
  logic ram_we, ram_cs, d_oe, ram_we_b, ram_cs_b, d_oe_b;
  logic [7:0] d_out, d_out_b;

  always #5 clk = ~clk;

  msx_slot_mapper #(
    .EXPANDED(4'b1000), .SEG_BITS(SegBits), .RAM_SLOT(3), .RAM_SUBSLOT(0)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_from_cpu(d_from_cpu),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .rfrsh_n(rfrsh_n), .ppi_a(ppi_a), .sltsl_n(sltsl_n), .subsl_n(subsl_n),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_cs(ram_cs), .d_out(d_out), .d_oe(d_oe)
  );

  // Same bus, no expanded slots.
  msx_slot_mapper #(
    .EXPANDED(4'b0000), .SEG_BITS(SegBits), .RAM_SLOT(3), .RAM_SUBSLOT(0)
  ) dut_b (
    .clk(clk), .reset(reset), .addr(addr), .d_from_cpu(d_from_cpu),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .rfrsh_n(rfrsh_n), .ppi_a(ppi_a), .sltsl_n(sltsl_n_b), .subsl_n(subsl_n_b),
    .ram_addr(ram_addr_b), .ram_we(ram_we_b), .ram_cs(ram_cs_b), .d_out(d_out_b),
    .d_oe(d_oe_b)
  );

  typedef enum int {
    FSltsl, FSubsl, FRamCs, FRamWe, FRamAddr, FDout, FDoe,
    BRamCs, BRamWe, BRamAddr, BSubsl, BDoe
  } field_e;

  typedef struct {
    string        tag;
    field_e       field;
    logic [31:0]  exp;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] observe(input field_e f);
    case (f)
      FSltsl:   return 32'(sltsl_n);
      FSubsl:   return 32'(subsl_n);
      FRamCs:   return 32'(ram_cs);
      FRamWe:   return 32'(ram_we);
      FRamAddr: return 32'(ram_addr);
      FDout:    return 32'(d_out);
      FDoe:     return 32'(d_oe);
      BRamCs:   return 32'(ram_cs_b);
      BRamWe:   return 32'(ram_we_b);
      BRamAddr: return 32'(ram_addr_b);
      BSubsl:   return 32'(subsl_n_b);
      BDoe:     return 32'(d_oe_b);
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input string tag, input field_e f, input logic [31:0] e);
    exp_t item;
    item.tag   = tag;
    item.field = f;
    item.exp   = e;
    sb.push_back(item);
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t item;
      item = sb.pop_front();
      check_val(item.tag, observe(item.field), item.exp);
    end
  endtask

  task automatic bus_idle();
    mreq_n  = 1'b1;
    iorq_n  = 1'b1;
    rd_n    = 1'b1;
    wr_n    = 1'b1;
    m1_n    = 1'b1;
    rfrsh_n = 1'b1;
  endtask

  task automatic start_cycle(input logic [15:0] a, input bit io, input bit wr,
                             input logic [7:0] d);
    @(negedge clk);
    addr       = a;
    d_from_cpu = d;
    if (io) iorq_n = 1'b0;
    else    mreq_n = 1'b0;
    if (wr) wr_n = 1'b0;
    else    rd_n = 1'b0;
    #2;
  endtask

  // Hold the strobes for n rising edges, then leave one idle edge so wr_n is
  // seen high before the next write.
  task automatic end_cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
    bus_idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    addr = 16'h0000;
    d_from_cpu = 8'h00;
    ppi_a = 8'h00;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle outputs after reset
    @(negedge clk);
    #2;
    expect_val("idle_sltsl", FSltsl, 32'hF);
    expect_val("idle_subsl", FSubsl, 32'hFFFF);
    expect_val("idle_ramcs", FRamCs, 0);
    expect_val("idle_ramwe", FRamWe, 0);
    expect_val("idle_doe",   FDoe,   0);
    expect_val("idle_dout",  FDout,  32'hFF);
    drain();

    // Mapper port readback after reset: FEh holds segment 1
    start_cycle(16'h00FE, 1'b1, 1'b0, 8'h00);
`ifdef MAPPER_READBACK_EN
    expect_val("rb_dout", FDout, 32'hF9);
    expect_val("rb_doe",  FDoe,  1);
`else
    expect_val("rb_dout", FDout, 32'hFF);
    expect_val("rb_doe",  FDoe,  0);
`endif
    drain();
    end_cycle(1);

    // Reset read of 0000h in slot 0
    ppi_a = 8'h00;
    start_cycle(16'h0000, 1'b0, 1'b0, 8'h00);
    expect_val("rst_sltsl", FSltsl, 32'hE);
    expect_val("rst_subsl", FSubsl, 32'hFFFF);
    expect_val("rst_ramcs", FRamCs, 0);
    expect_val("rst_doe",   FDoe,   0);
    drain();
    end_cycle(1);

    // FFFFh write: ordinary RAM write on non-expanded slot 3, register on expanded
    ppi_a = 8'hFF;
    start_cycle(16'hFFFF, 1'b0, 1'b1, 8'h00);
    expect_val("nx_b_ramwe",   BRamWe,   1);
    expect_val("nx_b_ramaddr", BRamAddr, 32'h03FFF);
    expect_val("nx_b_subsl",   BSubsl,   32'hFFFF);
    expect_val("nx_a_ramcs",   FRamCs,   0);
    expect_val("nx_a_subsl",   FSubsl,   32'hFFFF);
    expect_val("nx_a_sltsl",   FSltsl,   32'h7);
    drain();
    end_cycle(1);
    start_cycle(16'hFFFF, 1'b0, 1'b0, 8'h00);
    expect_val("nx_b_rd_doe",  BDoe,   0);
    expect_val("nx_b_rd_cs",   BRamCs, 1);
    expect_val("nx_a_rd_dout", FDout,  32'hFF);
    expect_val("nx_a_rd_doe",  FDoe,   1);
    drain();
    end_cycle(1);

    // Sub-slot register write; its own cycle keeps the old selects
    ppi_a = 8'hC0;
    start_cycle(16'hFFFF, 1'b0, 1'b1, 8'h5A);
    expect_val("ssw_sltsl", FSltsl, 32'h7);
    expect_val("ssw_subsl", FSubsl, 32'hFFFF);
    expect_val("ssw_ramcs", FRamCs, 0);
    drain();
    @(posedge clk);
    #1;
    expect_val("ssw_post_subsl", FSubsl, 32'hFFFF);
    expect_val("ssw_post_ramwe", FRamWe, 0);
    drain();
    end_cycle(0);
    start_cycle(16'hFFFF, 1'b0, 1'b0, 8'h00);
    expect_val("ssr_dout",  FDout,  32'hA5);
    expect_val("ssr_doe",   FDoe,   1);
    expect_val("ssr_subsl", FSubsl, 32'hFFFF);
    drain();
    end_cycle(1);
    ppi_a = 8'hCC;
    start_cycle(16'h4000, 1'b0, 1'b0, 8'h00);
    expect_val("sub_p1_subsl", FSubsl, 32'hBFFF);
    expect_val("sub_p1_sltsl", FSltsl, 32'h7);
    expect_val("sub_p1_ramcs", FRamCs, 0);
    drain();
    end_cycle(1);

    // Mapper paging: slot 3 sub 0 everywhere
    ppi_a = 8'hFF;
    start_cycle(16'hFFFF, 1'b0, 1'b1, 8'h00);
    end_cycle(1);
    start_cycle(16'h8001, 1'b0, 1'b0, 8'h00);
    expect_val("map0_ramcs",   FRamCs,   1);
    expect_val("map0_ramaddr", FRamAddr, 32'h04001);
    expect_val("map0_subsl",   FSubsl,   32'hEFFF);
    expect_val("map0_ramwe",   FRamWe,   0);
    drain();
    end_cycle(1);
    start_cycle(16'h00FE, 1'b1, 1'b1, 8'h05);
    expect_val("out_sltsl", FSltsl, 32'hF);
    expect_val("out_ramcs", FRamCs, 0);
    drain();
    end_cycle(1);
    start_cycle(16'h8001, 1'b0, 1'b1, 8'h00);
    expect_val("map1_ramaddr", FRamAddr, 32'h14001);
    expect_val("map1_ramwe",   FRamWe,   1);
    expect_val("map1_ramcs",   FRamCs,   1);
    drain();
    end_cycle(1);

    // Wait-stated OUT: only the data present at the first edge is taken
    start_cycle(16'h00FC, 1'b1, 1'b1, 8'h06);
    @(posedge clk);
    #1 d_from_cpu = 8'h07;
    end_cycle(3);
    start_cycle(16'h0000, 1'b0, 1'b0, 8'h00);
    expect_val("ws_ramaddr", FRamAddr, 32'h18000);
    drain();
    end_cycle(1);

    // Segment value truncated to SEG_BITS
    start_cycle(16'h00FD, 1'b1, 1'b1, 8'hFF);
    end_cycle(1);
    start_cycle(16'h4000, 1'b0, 1'b0, 8'h00);
    expect_val("trunc_ramaddr", FRamAddr, 32'h1C000);
    drain();
    end_cycle(1);

    // Refresh cycle: no selects, no register write
    rfrsh_n = 1'b0;
    start_cycle(16'hFFFF, 1'b0, 1'b1, 8'h55);
    expect_val("rf_sltsl", FSltsl, 32'hF);
    expect_val("rf_subsl", FSubsl, 32'hFFFF);
    expect_val("rf_ramcs", FRamCs, 0);
    expect_val("rf_ramwe", FRamWe, 0);
    drain();
    end_cycle(1);
    start_cycle(16'hFFFF, 1'b0, 1'b0, 8'h00);
    expect_val("rf_after_dout", FDout, 32'hFF);
    drain();
    end_cycle(1);

    // Reset in the middle of an OUT, released while wr_n is still low
    start_cycle(16'h00FF, 1'b1, 1'b1, 8'h06);
    @(posedge clk);
    #1 reset = 1'b1;
    #3 reset = 1'b0;
    end_cycle(2);
    start_cycle(16'h0000, 1'b0, 1'b0, 8'h00);
    expect_val("mr_seg0", FRamAddr, 32'h0C000);
    drain();
    end_cycle(1);
    start_cycle(16'h4000, 1'b0, 1'b0, 8'h00);
    expect_val("mr_seg1", FRamAddr, 32'h08000);
    drain();
    end_cycle(1);
    start_cycle(16'hC000, 1'b0, 1'b0, 8'h00);
    expect_val("mr_seg3", FRamAddr, 32'h00000);
    drain();
    end_cycle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
